// File: rtl/lcd_panel_responder.sv
// lcd_panel_responder
// Far-end model of an HD44780-style character panel on a 4-bit write-only bus.
// It samples a nibble on each falling edge of the enable strobe and follows the
// power-on init nibble sequence (3,3,3,2). After that it pairs nibbles into
// bytes, decodes commands, keeps the DDRAM address counter and the busy timer,
// and flags protocol violations.
//
// Ports
//   clk                     system clock, rising edge
//   iLCD_reset_n            asynchronous active-low reset
//   iLCD_Data[3:0]          data nibble
//   iLCD_Enabled            enable strobe, nibble taken on its falling edge
//   iLCD_RegisterSelect     0 = command, 1 = character data
//   iLCD_ReadWrite          must be 0
//   iLCD_StrataFlashControl must be 1 at every strobe
//   oInit_done              init nibble sequence completed
//   oBusy                   busy timer running
//   oCmd_valid / oCmd       one-cycle pulse and last command byte
//   oChar_valid / oChar     one-cycle pulse and last character byte
//   oChar_addr              DDRAM address the last character went to
//   oDDRAM_addr             current address counter
//   oDisplay_on             display-control D bit
//   oEntry_inc              entry-mode I/D bit
//   oError[3:0]             sticky: short strobe, strobe while busy, RW=1, flash low
`timescale 1ns/1ps
module lcd_panel_responder #(
  parameter int ENABLE_MIN   = 12,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       iLCD_reset_n,
  input  logic [3:0] iLCD_Data,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  output logic       oInit_done,
  output logic       oBusy,
  output logic       oCmd_valid,
  output logic [7:0] oCmd,
  output logic       oChar_valid,
  output logic [7:0] oChar,
  output logic [6:0] oChar_addr,
  output logic [6:0] oDDRAM_addr,
  output logic       oDisplay_on,
  output logic       oEntry_inc,
  output logic [3:0] oError
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam int HW_W  = $clog2(ENABLE_MIN + 1);
  localparam logic [CNT_W-1:0] LP_BUSY  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] LP_CLEAR = CNT_W'(CLEAR_CYCLES);
  localparam logic [HW_W-1:0]  LP_EMIN  = HW_W'(ENABLE_MIN);

  typedef enum logic [2:0] {
    INIT0, INIT1, INIT2, INIT3, BYTE_HI, BYTE_LO
  } state_t;

  state_t           r_state;
  logic             r_en_p0;
  logic [HW_W-1:0]  r_hw;
  logic [CNT_W-1:0] r_busy;
  logic [3:0]       r_hi;
  logic             r_hi_rs;

  logic             w_fall;
  logic [7:0]       w_byte;
  logic [3:0]       w_init_expect;

  // Two-line DDRAM map: line 1 is 0x00..0x27, line 2 is 0x40..0x67.
  // Addresses outside the map just step by one with 7-bit wrap.
  function automatic logic [6:0] f_advance(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == 7'h27)      n = 7'h40;
      else if (a == 7'h67) n = 7'h00;
      else                 n = a + 7'd1;
    end else begin
      if (a == 7'h00)      n = 7'h67;
      else if (a == 7'h40) n = 7'h27;
      else                 n = a - 7'd1;
    end
    return n;
  endfunction

  assign w_fall        = r_en_p0 & ~iLCD_Enabled;
  assign w_byte        = {r_hi, iLCD_Data};
  assign w_init_expect = (r_state == INIT3) ? 4'h2 : 4'h3;
  assign oBusy         = (r_busy != '0);

  always_ff @(posedge clk or negedge iLCD_reset_n) begin
    if (!iLCD_reset_n) begin
      r_state     <= INIT0;
      r_en_p0     <= 1'b0;
      r_hw        <= '0;
      r_busy      <= '0;
      r_hi        <= 4'h0;
      r_hi_rs     <= 1'b0;
      oInit_done  <= 1'b0;
      oCmd_valid  <= 1'b0;
      oCmd        <= 8'h00;
      oChar_valid <= 1'b0;
      oChar       <= 8'h00;
      oChar_addr  <= 7'h00;
      oDDRAM_addr <= 7'h00;
      oDisplay_on <= 1'b0;
      oEntry_inc  <= 1'b1;
      oError      <= 4'h0;
    end else begin
      // Strobe edge detect and saturating high-width measurement
      r_en_p0     <= iLCD_Enabled;
      if (iLCD_Enabled) begin
        if (r_hw < LP_EMIN) r_hw <= r_hw + 1'b1;
      end else begin
        r_hw <= '0;
      end
      oCmd_valid  <= 1'b0;
      oChar_valid <= 1'b0;
      if (r_busy != '0) r_busy <= r_busy - 1'b1;

      // Falling edge: reject bad strobes in priority order, else advance FSM.
      // Busy loads below override the decrement above.
      if (w_fall) begin
        if (r_hw < LP_EMIN)               oError[0] <= 1'b1;
        else if (oBusy)                   oError[1] <= 1'b1;
        else if (iLCD_ReadWrite)          oError[2] <= 1'b1;
        else if (!iLCD_StrataFlashControl) oError[3] <= 1'b1;
        else begin
          case (r_state)
            INIT0, INIT1, INIT2, INIT3: begin
              if (!iLCD_RegisterSelect && iLCD_Data == w_init_expect) begin
                r_busy <= LP_BUSY;
                case (r_state)
                  INIT0:   r_state <= INIT1;
                  INIT1:   r_state <= INIT2;
                  INIT2:   r_state <= INIT3;
                  default: begin
                    r_state    <= BYTE_HI;
                    oInit_done <= 1'b1;
                  end
                endcase
              end else begin
                r_state <= INIT0;
              end
            end
            BYTE_HI: begin
              r_hi    <= iLCD_Data;
              r_hi_rs <= iLCD_RegisterSelect;
              r_state <= BYTE_LO;
            end
            default: begin
              r_state <= BYTE_HI;
              r_busy  <= LP_BUSY;
              if (r_hi_rs) begin
                oChar_valid <= 1'b1;
                oChar       <= w_byte;
                oChar_addr  <= oDDRAM_addr;
                oDDRAM_addr <= f_advance(oDDRAM_addr, oEntry_inc);
              end else begin
                oCmd_valid <= 1'b1;
                oCmd       <= w_byte;
                casez (w_byte)
                  8'b1???????: oDDRAM_addr <= w_byte[6:0];
                  8'b01??????: ;
                  8'b001?????: ;
                  8'b00001???: oDisplay_on <= w_byte[2];
                  8'b000001??: oEntry_inc  <= w_byte[1];
                  8'b0000001?: begin
                    oDDRAM_addr <= 7'h00;
                    r_busy      <= LP_CLEAR;
                  end
                  8'b00000001: begin
                    oDDRAM_addr <= 7'h00;
                    oEntry_inc  <= 1'b1;
                    r_busy      <= LP_CLEAR;
                  end
                  default: ;
                endcase
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_panel_responder.sv
`timescale 1ns/1ps
module tb_lcd_panel_responder;

  localparam int EN_MIN = 4;
  localparam int BUSY   = 30;
  localparam int CLR    = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data = 4'h0;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0, fl = 1'b1;
  logic       oInit_done, oBusy, oCmd_valid, oChar_valid, oDisplay_on, oEntry_inc;
  logic [7:0] oCmd, oChar;
  logic [6:0] oChar_addr, oDDRAM_addr;
  logic [3:0] oError;

  lcd_panel_responder #(.ENABLE_MIN(EN_MIN), .BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .iLCD_reset_n(rst_n), .iLCD_Data(data), .iLCD_Enabled(en),
    .iLCD_RegisterSelect(rs), .iLCD_ReadWrite(rw), .iLCD_StrataFlashControl(fl),
    .oInit_done(oInit_done), .oBusy(oBusy), .oCmd_valid(oCmd_valid), .oCmd(oCmd),
    .oChar_valid(oChar_valid), .oChar(oChar), .oChar_addr(oChar_addr),
    .oDDRAM_addr(oDDRAM_addr), .oDisplay_on(oDisplay_on), .oEntry_inc(oEntry_inc),
    .oError(oError)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic is_char; logic [7:0] v; logic [6:0] a; } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  // Reference model state
  int     m_step;       // init nibbles accepted so far, 4 = byte mode
  bit     m_have_hi;
  int     m_hi, m_hi_rs;
  int     m_addr, m_entry, m_disp, m_err, m_done;
  longint m_load_idx, m_busy_len;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint edge_idx();
    return (longint'($time) - 5) / 10;
  endfunction

  function automatic int adv(input int a, input int inc);
    if (inc != 0) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
    return (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : (a + 127) % 128;
  endfunction

  function automatic int model_busy(input longint idx);
    return (m_busy_len > 0 && (idx - m_load_idx) < m_busy_len) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_step = 0; m_have_hi = 0; m_hi = 0; m_hi_rs = 0;
    m_addr = 0; m_entry = 1; m_disp = 0; m_err = 0; m_done = 0;
    m_load_idx = 0; m_busy_len = 0;
  endtask

  task automatic load_busy(input longint idx, input int len);
    m_load_idx = idx; m_busy_len = len;
  endtask

  // Apply one falling-edge strobe to the model; idx is the edge that sees it.
  task automatic model_strobe(input int d, input int r_s, input int r_w, input int f_l,
                              input int w, input longint idx);
    int b;
    ev_t e;
    if (w < EN_MIN)                      m_err |= 1;
    else if ((idx - m_load_idx) <= m_busy_len && m_busy_len > 0) m_err |= 2;
    else if (r_w != 0)                   m_err |= 4;
    else if (f_l == 0)                   m_err |= 8;
    else if (m_step < 4) begin
      if (r_s == 0 && d == ((m_step == 3) ? 2 : 3)) begin
        m_step++;
        load_busy(idx, BUSY);
        if (m_step == 4) m_done = 1;
      end else m_step = 0;
    end else if (!m_have_hi) begin
      m_hi = d; m_hi_rs = r_s; m_have_hi = 1;
    end else begin
      b = m_hi * 16 + d;
      m_have_hi = 0;
      load_busy(idx, BUSY);
      e.is_char = (m_hi_rs != 0); e.v = 8'(b); e.a = 7'(m_addr);
      exp_q.push_back(e);
      if (m_hi_rs != 0) m_addr = adv(m_addr, m_entry);
      else if (b >= 128) m_addr = b - 128;
      else if (b >= 32) ;
      else if (b >= 8) m_disp = (b >> 2) & 1;
      else if (b >= 4) m_entry = (b >> 1) & 1;
      else if (b >= 2) begin m_addr = 0; load_busy(idx, CLR); end
      else if (b == 1) begin m_addr = 0; m_entry = 1; load_busy(idx, CLR); end
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".init_done"}, oInit_done, m_done);
    chk({tag, ".error"}, oError, m_err);
    chk({tag, ".ddram"}, oDDRAM_addr, m_addr);
    chk({tag, ".disp"}, oDisplay_on, m_disp);
    chk({tag, ".entry"}, oEntry_inc, m_entry);
    chk({tag, ".busy"}, oBusy, model_busy(edge_idx()));
  endtask

  task automatic strobe(input int d, input int r_s, input int r_w, input int f_l, input int w);
    longint idx;
    @(posedge clk); #1;
    data = 4'(d); rs = r_s[0]; rw = r_w[0]; fl = f_l[0]; en = 1'b1;
    repeat (w) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    idx = edge_idx();
    model_strobe(d, r_s, r_w, f_l, w, idx);
    @(posedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input int b, input int r_s);
    strobe(b / 16, r_s, 0, 1, EN_MIN + 3);
    strobe(b % 16, r_s, 0, 1, EN_MIN + 3);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    en = 1'b0; rw = 1'b0; fl = 1'b1; rst_n = 1'b0;
    model_reset();
    gap(2); #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst.init_done", oInit_done, 0); chk("rst.busy", oBusy, 0);
    chk("rst.cmd_valid", oCmd_valid, 0); chk("rst.cmd", oCmd, 0);
    chk("rst.char_valid", oChar_valid, 0); chk("rst.char", oChar, 0);
    chk("rst.char_addr", oChar_addr, 0); chk("rst.ddram", oDDRAM_addr, 0);
    chk("rst.disp", oDisplay_on, 0); chk("rst.entry", oEntry_inc, 1);
    chk("rst.error", oError, 0);
  endtask

  task automatic do_init();
    strobe(3, 0, 0, 1, 20); check_state("init1"); gap(BUSY + 5);
    strobe(3, 0, 0, 1, 20); check_state("init2"); gap(BUSY + 5);
    strobe(3, 0, 0, 1, 20); check_state("init3"); gap(BUSY + 5);
    strobe(2, 0, 0, 1, 20); check_state("init4"); gap(BUSY + 5);
  endtask

  // Scoreboard monitor: every decode pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (oChar_valid || oCmd_valid)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {oChar_valid, oCmd_valid}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", oChar_valid, mon_e.is_char);
        if (mon_e.is_char) begin
          chk("char", oChar, mon_e.v);
          chk("char_addr", oChar_addr, mon_e.a);
        end else begin
          chk("cmd", oCmd, mon_e.v);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r_s, r_w, f_l, w;
    model_reset();
    gap(3); #1 rst_n = 1'b1;
    check_reset_outputs();

    do_init();

    send_byte('h0C, 0); check_state("disp_on"); gap(BUSY + 5); check_state("disp_on_idle");
    send_byte('h06, 0); check_state("entry");   gap(BUSY + 5);

    send_byte('hA7, 0); gap(BUSY + 5);
    send_byte('h41, 1); gap(BUSY + 5);
    send_byte('h42, 1); check_state("chars");   gap(BUSY + 5);

    send_byte('h01, 0); gap(10);
    strobe(5, 0, 0, 1, EN_MIN + 3); check_state("while_busy");
    gap(CLR + 5); check_state("clear_done");

    strobe(4, 1, 0, 1, EN_MIN - 1); check_state("short");
    strobe(4, 1, 0, 1, EN_MIN);     check_state("width_edge");
    strobe(2, 0, 1, 1, EN_MIN + 2); check_state("rw");
    strobe(2, 0, 0, 0, EN_MIN + 2); check_state("flash");
    strobe(1, 1, 0, 1, EN_MIN + 2); check_state("low_after_errs");
    gap(BUSY + 5);

    do_reset(); check_reset_outputs();
    do_init();
    strobe(4, 1, 0, 1, EN_MIN + 2);
    do_reset(); check_reset_outputs();
    do_init();

    for (int i = 0; i < 120; i++) begin
      d   = $urandom_range(0, 15);
      r_s = $urandom_range(0, 1);
      w   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, EN_MIN - 1)
                                        : $urandom_range(EN_MIN, EN_MIN + 5);
      r_w = ($urandom_range(0, 19) == 0) ? 1 : 0;
      f_l = ($urandom_range(0, 19) == 0) ? 0 : 1;
      strobe(d, r_s, r_w, f_l, w);
      check_state("rand");
      gap(($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : CLR + 3);
    end

    gap(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
